// File: rtl/mips_fetch_pkg.sv
//------------------------------------------------------------------------------
// Module   : mips_fetch_pkg
// Purpose  : Shared fetch-stage types and constants. Holds the fetch FSM state
//            encoding, the datapath width and the default reset PC.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // IDLE: one dead cycle out of reset; FETCH: normal sequencing;
  // DROP: waiting for the ack of a request that a redirect orphaned
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DROP  = 2'd2
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/add4.sv
//------------------------------------------------------------------------------
// Module   : add4
// Purpose  : PC incrementer, returns i_a + 4 modulo 2^W.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module add4 #(
  parameter int W = 32
) (
  input  logic [W-1:0] i_a,
  output logic [W-1:0] o_sum
);

  // Carry out of the top bit is dropped, so the all-ones word aligned PC wraps to 0
  assign o_sum = i_a + W'(4);

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
//------------------------------------------------------------------------------
// Module   : pc_sequencer
// Purpose  : Fetch-stage controller. Owns the architectural PC, issues one
//            outstanding instruction-memory request at a time, buffers one
//            instruction toward decode and redirects on taken branches.
// Config   : PC_SEQ_JUMP_EN - adds JumpD/JumpIdxD/PCPlus4D and jump redirects.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pc_sequencer
  import mips_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            StallF,
  input  logic            PCSrcD,
  input  logic [XLEN-1:0] PCBranchD,
`ifdef PC_SEQ_JUMP_EN
  input  logic            JumpD,
  input  logic [25:0]     JumpIdxD,
  input  logic [XLEN-1:0] PCPlus4D,
`endif
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] PCPlus4F,
  output logic            ValidF
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pcf;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pcplus4;
  logic            r_valid;
  logic            r_outstanding;

  logic            w_req;
  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_pcf_plus4;
  logic [XLEN-1:0] w_pcf_nxt;
  logic            w_ack_take;
  logic            w_unused;

  add4 #(.W(XLEN)) u_add4 (
    .i_a   (r_pcf),
    .o_sum (w_pcf_plus4)
  );

  // Redirect selection: branch has priority over jump; targets are word aligned
  always_comb begin
    w_redirect = PCSrcD;
    w_target   = {PCBranchD[XLEN-1:2], 2'b00};
`ifdef PC_SEQ_JUMP_EN
    if (!PCSrcD && JumpD) begin
      w_redirect = 1'b1;
      w_target   = {PCPlus4D[31:28], JumpIdxD, 2'b00};
    end
`endif
  end

`ifdef PC_SEQ_JUMP_EN
  assign w_unused = ^{PCBranchD[1:0], PCPlus4D[27:0]};
`else
  assign w_unused = ^PCBranchD[1:0];
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state and request decode; a new request only issues when the buffer
  // is empty or being drained, so an ack can never overwrite a held instruction
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    unique case (r_state)
      ST_IDLE: w_state_nxt = ST_FETCH;
      ST_FETCH: begin
        w_req = r_outstanding || !(r_valid && StallF);
        if (w_redirect && w_req && !imem_ack) w_state_nxt = ST_DROP;
      end
      ST_DROP: begin
        w_req = 1'b1;
        if (imem_ack) w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_ack_take = (r_state == ST_FETCH) && w_req && imem_ack;

  // Next PC: redirect beats sequential advance; nothing moves in IDLE
  always_comb begin
    w_pcf_nxt = r_pcf;
    if (r_state != ST_IDLE) begin
      if (w_redirect)      w_pcf_nxt = w_target;
      else if (w_ack_take) w_pcf_nxt = w_pcf_plus4;
    end
  end

  // Fetch datapath: PC, request address shadow, decode buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pcf         <= RESET_PC;
      r_addr        <= RESET_PC;
      r_instr       <= '0;
      r_pcplus4     <= '0;
      r_valid       <= 1'b0;
      r_outstanding <= 1'b0;
    end else begin
      r_pcf <= w_pcf_nxt;
      // While an orphaned request is pending the old address must stay on the bus
      if (w_state_nxt != ST_DROP) r_addr <= w_pcf_nxt;
      r_outstanding <= (r_state == ST_FETCH) && w_req && !imem_ack && !w_redirect;
      if (r_state == ST_FETCH) begin
        if (w_redirect) begin
          r_valid <= 1'b0;
        end else if (w_ack_take) begin
          r_valid   <= 1'b1;
          r_instr   <= imem_rdata;
          r_pcplus4 <= w_pcf_plus4;
        end else if (r_valid && !StallF) begin
          r_valid <= 1'b0;
        end
      end
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = r_addr;
  assign PCF       = r_pcf;
  assign InstrF    = r_instr;
  assign PCPlus4F  = r_pcplus4;
  assign ValidF    = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
//------------------------------------------------------------------------------
// Module   : tb_pc_sequencer
// Purpose  : Self-checking bench for pc_sequencer: directed scenarios plus a
//            randomized run against an in-order instruction-stream model.
// Config   : PC_SEQ_JUMP_EN - enables the jump scenario and random jumps.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pc_sequencer;
  import mips_fetch_pkg::*;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallF = 1'b0;
  logic        PCSrcD = 1'b0;
  logic [31:0] PCBranchD = '0;
`ifdef PC_SEQ_JUMP_EN
  logic        JumpD = 1'b0;
  logic [25:0] JumpIdxD = '0;
  logic [31:0] PCPlus4D = '0;
`endif
  logic        imem_req;
  logic        imem_ack;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic [31:0] PCPlus4F;
  logic        ValidF;

  int mem_wait = 0;
  int mem_cnt;
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory model: acks after mem_wait cycles of held request
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       mem_cnt <= 0;
    else if (imem_req && !imem_ack)   mem_cnt <= mem_cnt + 1;
    else                              mem_cnt <= 0;
  end
  assign imem_ack   = imem_req && (mem_cnt >= mem_wait);
  assign imem_rdata = memf(imem_addr);

  pc_sequencer #(.RESET_PC(RPC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .StallF     (StallF),
    .PCSrcD     (PCSrcD),
    .PCBranchD  (PCBranchD),
`ifdef PC_SEQ_JUMP_EN
    .JumpD      (JumpD),
    .JumpIdxD   (JumpIdxD),
    .PCPlus4D   (PCPlus4D),
`endif
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .PCF        (PCF),
    .InstrF     (InstrF),
    .PCPlus4F   (PCPlus4F),
    .ValidF     (ValidF)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    StallF    = 1'b0;
    PCSrcD    = 1'b0;
    PCBranchD = '0;
`ifdef PC_SEQ_JUMP_EN
    JumpD    = 1'b0;
    JumpIdxD = '0;
    PCPlus4D = '0;
`endif
  endtask

  // Leaves the bench at the start of the first FETCH cycle
  task automatic reset_dut(input int waits);
    rst_n = 1'b0;
    idle_inputs();
    mem_wait = waits;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    mem_wait = 0;
    tick();
    #1;
    n_total++; if (PCF !== RPC) $display("FAIL rst_pcf got %h want %h", PCF, RPC); else n_pass++;
    n_total++; if (imem_addr !== RPC) $display("FAIL rst_addr got %h want %h", imem_addr, RPC); else n_pass++;
    n_total++; if (imem_req !== 1'b0) $display("FAIL rst_req got %b want 0", imem_req); else n_pass++;
    n_total++; if (ValidF !== 1'b0) $display("FAIL rst_valid got %b want 0", ValidF); else n_pass++;
    n_total++; if (InstrF !== 32'h0) $display("FAIL rst_instr got %h want 0", InstrF); else n_pass++;
    n_total++; if (PCPlus4F !== 32'h0) $display("FAIL rst_pcplus4 got %h want 0", PCPlus4F); else n_pass++;
    tick();
    rst_n = 1'b1;
    #1;
    n_total++; if (imem_req !== 1'b0) $display("FAIL idle_req got %b want 0", imem_req); else n_pass++;
    tick();
    #1;
    n_total++;
    if ({imem_req, imem_addr} !== {1'b1, RPC})
      $display("FAIL first_req got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, RPC);
    else n_pass++;
  endtask

  task automatic test_zero_wait();
    reset_dut(0);
    for (int k = 0; k < 6; k++) begin
      #1;
      n_total++;
      if ({imem_req, imem_addr} !== {1'b1, RPC + 32'(4 * k)})
        $display("FAIL zw_req k=%0d got req=%b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, RPC + 32'(4 * k));
      else n_pass++;
      if (k > 0) begin
        n_total++;
        if ({ValidF, InstrF, PCPlus4F} !== {1'b1, memf(RPC + 32'(4 * (k - 1))), RPC + 32'(4 * k)})
          $display("FAIL zw_data k=%0d got v=%b instr=%h pc4=%h", k, ValidF, InstrF, PCPlus4F);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_stall();
    reset_dut(0);
    for (int k = 0; k < 8; k++) begin
      StallF = (k >= 2 && k <= 4);
      #1;
      if (k >= 2 && k <= 4) begin
        n_total++;
        if ({imem_req, ValidF, InstrF, imem_addr} !== {1'b0, 1'b1, memf(32'h104), 32'h108})
          $display("FAIL stall_hold k=%0d got req=%b v=%b instr=%h addr=%h", k, imem_req, ValidF, InstrF, imem_addr);
        else n_pass++;
      end
      if (k == 5) begin
        n_total++;
        if ({imem_req, imem_addr, InstrF} !== {1'b1, 32'h108, memf(32'h104)})
          $display("FAIL stall_resume got req=%b addr=%h instr=%h", imem_req, imem_addr, InstrF);
        else n_pass++;
      end
      if (k == 6) begin
        n_total++;
        if ({ValidF, InstrF} !== {1'b1, memf(32'h108)})
          $display("FAIL stall_next got v=%b instr=%h want %h", ValidF, InstrF, memf(32'h108));
        else n_pass++;
      end
      tick();
    end
    StallF = 1'b0;
  endtask

  task automatic test_drop();
    reset_dut(3);
    for (int k = 0; k < 10; k++) begin
      PCSrcD    = (k == 1);
      PCBranchD = 32'h0000_2000;
      #1;
      if (k >= 2 && k <= 7) begin
        n_total++;
        if (ValidF !== 1'b0) $display("FAIL drop_valid k=%0d got %b want 0", k, ValidF); else n_pass++;
      end
      if (k == 2 || k == 3) begin
        n_total++;
        if ({PCF, imem_addr, imem_req} !== {32'h2000, 32'h100, 1'b1})
          $display("FAIL drop_shadow k=%0d got pcf=%h addr=%h req=%b", k, PCF, imem_addr, imem_req);
        else n_pass++;
      end
      if (k == 4) begin
        n_total++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h2000})
          $display("FAIL drop_refetch got req=%b addr=%h want addr=00002000", imem_req, imem_addr);
        else n_pass++;
      end
      if (k == 8) begin
        n_total++;
        if ({ValidF, InstrF} !== {1'b1, memf(32'h2000)})
          $display("FAIL drop_data got v=%b instr=%h want %h", ValidF, InstrF, memf(32'h2000));
        else n_pass++;
      end
      tick();
    end
    idle_inputs();
  endtask

`ifdef PC_SEQ_JUMP_EN
  task automatic test_jump();
    reset_dut(0);
    tick();
    PCSrcD    = 1'b1;
    PCBranchD = 32'h0000_3001;
    JumpD     = 1'b1;
    JumpIdxD  = 26'h3FF_FFFF;
    PCPlus4D  = 32'h8000_0000;
    tick();
    idle_inputs();
    #1;
    n_total++;
    if ({PCF, imem_addr, ValidF} !== {32'h3000, 32'h3000, 1'b0})
      $display("FAIL jump_prio got pcf=%h addr=%h v=%b want pcf=00003000", PCF, imem_addr, ValidF);
    else n_pass++;
    tick();
    JumpD    = 1'b1;
    JumpIdxD = 26'h000_0123;
    PCPlus4D = 32'h4000_0010;
    tick();
    idle_inputs();
    #1;
    n_total++;
    if ({PCF, ValidF} !== {32'h4000_048C, 1'b0})
      $display("FAIL jump_target got pcf=%h v=%b want pcf=4000048c", PCF, ValidF);
    else n_pass++;
    tick();
  endtask
`endif

  task automatic test_wrap();
    reset_dut(0);
    PCSrcD    = 1'b1;
    PCBranchD = 32'hFFFF_FFFC;
    tick();
    idle_inputs();
    #1;
    n_total++;
    if ({PCF, imem_req} !== {32'hFFFF_FFFC, 1'b1})
      $display("FAIL wrap_pre got pcf=%h req=%b", PCF, imem_req);
    else n_pass++;
    tick();
    #1;
    n_total++;
    if ({PCF, PCPlus4F, imem_addr} !== {32'h0, 32'h0, 32'h0})
      $display("FAIL wrap_pc got pcf=%h pc4=%h addr=%h want all 0", PCF, PCPlus4F, imem_addr);
    else n_pass++;
    n_total++;
    if ({ValidF, InstrF} !== {1'b1, memf(32'hFFFF_FFFC)})
      $display("FAIL wrap_data got v=%b instr=%h", ValidF, InstrF);
    else n_pass++;
    tick();
  endtask

  task automatic test_async_reset();
    reset_dut(2);
    tick();
    tick();
    tick();
    #1;
    n_total++;
    if ({ValidF, imem_req, imem_addr} !== {1'b1, 1'b1, RPC + 32'h4})
      $display("FAIL areset_pre got v=%b req=%b addr=%h", ValidF, imem_req, imem_addr);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({PCF, imem_addr, imem_req, ValidF, InstrF, PCPlus4F} !== {RPC, RPC, 1'b0, 1'b0, 32'h0, 32'h0})
      $display("FAIL areset_vals got pcf=%h addr=%h req=%b v=%b instr=%h pc4=%h",
               PCF, imem_addr, imem_req, ValidF, InstrF, PCPlus4F);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    #1;
    n_total++;
    if (imem_req !== 1'b0) $display("FAIL areset_idle got req=%b want 0", imem_req); else n_pass++;
    tick();
    #1;
    n_total++;
    if ({imem_req, imem_addr} !== {1'b1, RPC})
      $display("FAIL areset_restart got req=%b addr=%h want %h", imem_req, imem_addr, RPC);
    else n_pass++;
    tick();
  endtask

  // Decode sees an in-order stream: next PC advances by 4 per consumed
  // instruction and jumps to the redirect target on every redirect
  task automatic test_random();
    logic [31:0] exp_ptr;
    logic [31:0] tgt;
    logic [31:0] prev_addr;
    logic        prev_req;
    logic        prev_ack;
    logic        redir;
    int          delivered;
    reset_dut(int'($urandom_range(0, 3)));
    exp_ptr   = RPC;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = '0;
    delivered = 0;
    for (int c = 0; c < 2000; c++) begin
      StallF    = ($urandom_range(0, 9) < 3);
      mem_wait  = int'($urandom_range(0, 3));
      PCSrcD    = ($urandom_range(0, 99) < 8);
      PCBranchD = $urandom;
      redir     = PCSrcD;
      tgt       = PCBranchD & 32'hFFFF_FFFC;
`ifdef PC_SEQ_JUMP_EN
      JumpD    = ($urandom_range(0, 99) < 5);
      JumpIdxD = 26'($urandom);
      PCPlus4D = $urandom;
      if (!PCSrcD && JumpD) begin
        redir = 1'b1;
        tgt   = {PCPlus4D[31:28], JumpIdxD, 2'b00};
      end
`endif
      #1;
      if (prev_req && !prev_ack) begin
        n_total++;
        if ({imem_req, imem_addr} !== {1'b1, prev_addr})
          $display("FAIL rnd_hold c=%0d got req=%b addr=%h want req=1 addr=%h", c, imem_req, imem_addr, prev_addr);
        else n_pass++;
      end
      if (ValidF && !StallF && !redir) begin
        n_total++;
        if ({InstrF, PCPlus4F} !== {memf(exp_ptr), exp_ptr + 32'h4})
          $display("FAIL rnd_stream c=%0d got instr=%h pc4=%h want instr=%h pc4=%h",
                   c, InstrF, PCPlus4F, memf(exp_ptr), exp_ptr + 32'h4);
        else n_pass++;
        exp_ptr = exp_ptr + 32'h4;
        delivered++;
      end
      if (redir) exp_ptr = tgt;
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
      tick();
    end
    idle_inputs();
    n_total++;
    if (delivered < 100) $display("FAIL rnd_progress got %0d deliveries want >=100", delivered);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_drop();
`ifdef PC_SEQ_JUMP_EN
    test_jump();
`endif
    test_wrap();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish, %0d/%0d so far", n_pass, n_total);
    $fatal(1);
  end

endmodule

`default_nettype wire
